// File: rtl/clock_time_counter_pkg.sv
// -----------------------------------------------------------------------------
// clock_time_counter_pkg
// Shared constants, alarm FSM state type and BCD helper functions for the
// time-of-day counter.
//   BCD_DIGIT_W        width of one BCD digit
//   SEC_MAX / MIN_MAX  last legal seconds / minutes value (59)
//   HOUR_24_MAX        last hour in 24-hour mode (23)
//   HOUR_12_MAX        last hour in 12-hour mode (12)
//   HOUR_12_MIN        first hour in 12-hour mode (01)
//   ALARM_CNT_W        width of the alarm ring-duration tick counter
// -----------------------------------------------------------------------------
package clock_time_counter_pkg;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [7:0] SEC_MAX     = 8'h59;
   localparam logic [7:0] MIN_MAX     = 8'h59;
   localparam logic [7:0] HOUR_24_MAX = 8'h23;
   localparam logic [7:0] HOUR_12_MAX = 8'h12;
   localparam logic [7:0] HOUR_12_MIN = 8'h01;
   localparam logic [7:0] BCD_ZERO    = 8'h00;
   localparam int         ALARM_CNT_W = 16;

   typedef enum logic {
      ALARM_IDLE = 1'b0,
      ALARM_RING = 1'b1
   } alarm_state_e;

   // Two-digit BCD increment. Any digit at or above 9 is treated as 9, so an
   // illegal value can never propagate into a wider illegal value.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [BCD_DIGIT_W-1:0] lo;
      logic [BCD_DIGIT_W-1:0] hi;
      lo = v[3:0];
      hi = v[7:4];
      if (lo >= 4'd9) begin
         lo = 4'd0;
         if (hi >= 4'd9) begin
            hi = 4'd0;
         end else begin
            hi = hi + 4'd1;
         end
      end else begin
         lo = lo + 4'd1;
      end
      return {hi, lo};
   endfunction

   // Modular BCD step: wrap to lo_val after reaching hi_val.
   function automatic logic [7:0] bcd_step(input logic [7:0] v,
                                           input logic [7:0] hi_val,
                                           input logic [7:0] lo_val);
      logic [7:0] r;
      if (v == hi_val) begin
         r = lo_val;
      end else begin
         r = bcd_inc(v);
      end
      return r;
   endfunction

   // Binary (0-99) to two-digit BCD, used for elaboration-time reset values.
   function automatic logic [7:0] bin_to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'((v / 32'sd10) % 32'sd10);
      r[3:0] = 4'(v % 32'sd10);
      return r;
   endfunction

endpackage

// File: rtl/clock_time_counter_bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD modular counter (min..max) with synchronous load.
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high, loads RST_VAL
//   en         in   count enable (one step per enabled cycle)
//   load       in   synchronous load of load_val, overrides en
//   load_val   in   8  value loaded when load=1
//   max        in   8  last value before wrap
//   min        in   8  value after wrap
//   q          out  8  registered count
//   carry_out  out  1  combinational: en & (q == max), i.e. wrap this edge
// -----------------------------------------------------------------------------
module bcd_mod_counter
   import clock_time_counter_pkg::*;
#(
   parameter logic [7:0] RST_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic [7:0] max,
   input  logic [7:0] min,
   output logic [7:0] q,
   output logic       carry_out
);

   logic [7:0] q_r;

   // Count register: reset, then load, then enabled modular step.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r <= RST_VAL;
      end else if (load) begin
         q_r <= load_val;
      end else if (en) begin
         q_r <= bcd_step(q_r, max, min);
      end else begin
         q_r <= q_r;
      end
   end

   assign q         = q_r;
   // Carry is asserted in the same cycle as the wrapping enable so the next
   // digit advances on the same edge as this one wraps.
   assign carry_out = en & (q_r == max);

endmodule

// File: rtl/clock_time_counter.sv
// -----------------------------------------------------------------------------
// clock_time_counter
// BCD HH:MM:SS time-of-day counter driven by a 1 Hz enable in the 50 MHz
// domain, with manual hour/minute set and an optional alarm.
// Optional feature macro: CLOCK_ALARM_EN (alarm comparator and ring FSM).
// Parameters:
//   HOURS_MAX   24 (00-23) or 12 (01-12)
//   INIT_HOUR   reset hour, binary (use 12 with HOURS_MAX=12)
//   INIT_MIN    reset minute, binary 0-59
//   ALARM_SECS  ticks alarm_ring stays high without ack
// Ports:
//   clk_in_50M  in   50 MHz clock
//   rst_in      in   synchronous reset, active-high
//   sec_tick    in   1-cycle 1 Hz enable
//   set_mode    in   1 = time frozen, seconds held at 00, inc inputs active
//   inc_hour    in   hour+1 pulse (set mode)
//   inc_min     in   minute+1 pulse (set mode)
//   alarm_hour  in   8  BCD alarm hour
//   alarm_min   in   8  BCD alarm minute
//   alarm_ack   in   clears alarm_ring
//   hour_bcd    out  8  BCD hour
//   min_bcd     out  8  BCD minute
//   sec_bcd     out  8  BCD second
//   min_carry   out  pulse when seconds wrap 59->00
//   hour_carry  out  pulse when MM:SS wraps 59:59->00:00
//   alarm_ring  out  alarm active (always 0 without CLOCK_ALARM_EN)
// -----------------------------------------------------------------------------
module clock_time_counter
   import clock_time_counter_pkg::*;
#(
   parameter int HOURS_MAX  = 24,
   parameter int INIT_HOUR  = 0,
   parameter int INIT_MIN   = 0,
   parameter int ALARM_SECS = 60
) (
   input  logic       clk_in_50M,
   input  logic       rst_in,
   input  logic       sec_tick,
   input  logic       set_mode,
   input  logic       inc_hour,
   input  logic       inc_min,
   input  logic [7:0] alarm_hour,
   input  logic [7:0] alarm_min,
   input  logic       alarm_ack,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       min_carry,
   output logic       hour_carry,
   output logic       alarm_ring
);

   localparam logic [7:0] HOUR_HI_C   = (HOURS_MAX == 12) ? HOUR_12_MAX : HOUR_24_MAX;
   localparam logic [7:0] HOUR_LO_C   = (HOURS_MAX == 12) ? HOUR_12_MIN : BCD_ZERO;
   localparam logic [7:0] INIT_HOUR_C = bin_to_bcd(INIT_HOUR);
   localparam logic [7:0] INIT_MIN_C  = bin_to_bcd(INIT_MIN);

   logic       run_s;
   logic       sec_en_s;
   logic       min_en_s;
   logic       hour_en_s;
   logic       sec_co_s;
   logic       min_co_s;
   logic       hour_co_unused_s;
   logic [7:0] sec_q_s;
   logic [7:0] min_q_s;
   logic [7:0] hour_q_s;
   logic       min_carry_r;
   logic       hour_carry_r;

   assign run_s    = ~set_mode;
   assign sec_en_s = sec_tick & run_s;
   // In set mode the minute and hour digits take the manual pulses and the
   // seconds-to-minutes chain is cut, so a minute wrap never reaches hours.
   assign min_en_s  = set_mode ? inc_min  : sec_co_s;
   assign hour_en_s = set_mode ? inc_hour : min_co_s;

   bcd_mod_counter #(.RST_VAL(BCD_ZERO)) u_sec (
      .clk       (clk_in_50M),
      .rst       (rst_in),
      .en        (sec_en_s),
      .load      (set_mode),
      .load_val  (BCD_ZERO),
      .max       (SEC_MAX),
      .min       (BCD_ZERO),
      .q         (sec_q_s),
      .carry_out (sec_co_s)
   );

   bcd_mod_counter #(.RST_VAL(INIT_MIN_C)) u_min (
      .clk       (clk_in_50M),
      .rst       (rst_in),
      .en        (min_en_s),
      .load      (1'b0),
      .load_val  (BCD_ZERO),
      .max       (MIN_MAX),
      .min       (BCD_ZERO),
      .q         (min_q_s),
      .carry_out (min_co_s)
   );

   bcd_mod_counter #(.RST_VAL(INIT_HOUR_C)) u_hour (
      .clk       (clk_in_50M),
      .rst       (rst_in),
      .en        (hour_en_s),
      .load      (1'b0),
      .load_val  (BCD_ZERO),
      .max       (HOUR_HI_C),
      .min       (HOUR_LO_C),
      .q         (hour_q_s),
      .carry_out (hour_co_unused_s)
   );

   // Carry pulse registers: one cycle, on the same edge as the wrap, run mode only.
   always_ff @(posedge clk_in_50M) begin
      if (rst_in) begin
         min_carry_r  <= 1'b0;
         hour_carry_r <= 1'b0;
      end else begin
         min_carry_r  <= sec_co_s;
         hour_carry_r <= run_s & min_co_s;
      end
   end

   assign hour_bcd   = hour_q_s;
   assign min_bcd    = min_q_s;
   assign sec_bcd    = sec_q_s;
   assign min_carry  = min_carry_r;
   assign hour_carry = hour_carry_r;

`ifdef CLOCK_ALARM_EN
   localparam logic [ALARM_CNT_W-1:0] ALARM_LAST_C = ALARM_CNT_W'(ALARM_SECS - 1);

   alarm_state_e           state_r;
   alarm_state_e           state_nx_s;
   logic [ALARM_CNT_W-1:0] cnt_r;
   logic [ALARM_CNT_W-1:0] cnt_nx_s;
   logic [7:0]             min_next_s;
   logic [7:0]             hour_next_s;
   logic                   match_s;

   // The alarm fires on the edge that produces HH:MM:00, so compare against
   // the values the counters will hold after this tick, not the current ones.
   assign min_next_s  = bcd_step(min_q_s, MIN_MAX, BCD_ZERO);
   assign hour_next_s = min_co_s ? bcd_step(hour_q_s, HOUR_HI_C, HOUR_LO_C) : hour_q_s;
   assign match_s     = sec_co_s & (hour_next_s == alarm_hour) & (min_next_s == alarm_min);

   // Alarm state and ring-duration counter registers.
   always_ff @(posedge clk_in_50M) begin
      if (rst_in) begin
         state_r <= ALARM_IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
      end
   end

   // Alarm next-state: ack beats a simultaneous match; ringing ends on ack,
   // set mode, or after ALARM_SECS run-mode ticks.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      case (state_r)
         ALARM_IDLE: begin
            cnt_nx_s = '0;
            if (match_s && !alarm_ack) begin
               state_nx_s = ALARM_RING;
            end else begin
               state_nx_s = ALARM_IDLE;
            end
         end
         ALARM_RING: begin
            if (alarm_ack || set_mode) begin
               state_nx_s = ALARM_IDLE;
               cnt_nx_s   = '0;
            end else if (sec_tick) begin
               if (cnt_r >= ALARM_LAST_C) begin
                  state_nx_s = ALARM_IDLE;
                  cnt_nx_s   = '0;
               end else begin
                  state_nx_s = ALARM_RING;
                  cnt_nx_s   = cnt_r + 1'b1;
               end
            end else begin
               state_nx_s = ALARM_RING;
               cnt_nx_s   = cnt_r;
            end
         end
         default: begin
            state_nx_s = ALARM_IDLE;
            cnt_nx_s   = '0;
         end
      endcase
   end

   assign alarm_ring = (state_r == ALARM_RING);
`else
   logic alarm_inputs_unused_s;

   assign alarm_inputs_unused_s = ^{alarm_hour, alarm_min, alarm_ack};
   assign alarm_ring            = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_counter.sv
module tb_clock_time_counter;

   logic       clk = 1'b0;
   logic       rst_in, sec_tick, set_mode, inc_hour, inc_min, alarm_ack;
   logic [7:0] alarm_hour, alarm_min;
   logic [7:0] h24, m24, s24, h12, m12, s12;
   logic       mc24, hc24, ar24, mc12, hc12, ar12;

   clock_time_counter dut (
      .clk_in_50M(clk), .rst_in(rst_in), .sec_tick(sec_tick), .set_mode(set_mode),
      .inc_hour(inc_hour), .inc_min(inc_min), .alarm_hour(alarm_hour),
      .alarm_min(alarm_min), .alarm_ack(alarm_ack), .hour_bcd(h24), .min_bcd(m24),
      .sec_bcd(s24), .min_carry(mc24), .hour_carry(hc24), .alarm_ring(ar24));

   clock_time_counter #(.HOURS_MAX(12), .INIT_HOUR(12)) dut12 (
      .clk_in_50M(clk), .rst_in(rst_in), .sec_tick(sec_tick), .set_mode(set_mode),
      .inc_hour(inc_hour), .inc_min(inc_min), .alarm_hour(alarm_hour),
      .alarm_min(alarm_min), .alarm_ack(alarm_ack), .hour_bcd(h12), .min_bcd(m12),
      .sec_bcd(s12), .min_carry(mc12), .hour_carry(hc12), .alarm_ring(ar12));

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      int         cyc;
      bit         d12;
      logic [7:0] h, m, s;
      logic       mc, hc, ring;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   exp_t        mon_e;
   logic [26:0] mon_act, mon_req;

   // Monitor: compares every expectation due at this cycle, away from the edge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
         mon_e   = sb.pop_front();
         mon_act = mon_e.d12 ? {h12, m12, s12, mc12, hc12, ar12}
                             : {h24, m24, s24, mc24, hc24, ar24};
         mon_req = {mon_e.h, mon_e.m, mon_e.s, mon_e.mc, mon_e.hc, mon_e.ring};
         n_tests++;
         if (mon_e.cyc != cyc_cnt || mon_act !== mon_req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h:%h:%h mc=%b hc=%b ring=%b, expected %h:%h:%h mc=%b hc=%b ring=%b",
                     mon_e.name, cyc_cnt, mon_act[26:19], mon_act[18:11], mon_act[10:3],
                     mon_act[2], mon_act[1], mon_act[0], mon_req[26:19], mon_req[18:11],
                     mon_req[10:3], mon_req[2], mon_req[1], mon_req[0]);
         end
      end
   end

   function automatic logic [7:0] bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   // Queue the expected outputs after the next active edge.
   task automatic expect_nx(input string nm, input bit d12, input logic [7:0] h, m, s,
                            input logic mc, hc, ring);
      exp_t e;
      e.cyc = cyc_cnt + 1; e.d12 = d12; e.h = h; e.m = m; e.s = s;
      e.mc = mc; e.hc = hc; e.ring = ring; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic step(input logic r, st, tk, ih, im, ack);
      rst_in = r; set_mode = st; sec_tick = tk; inc_hour = ih; inc_min = im; alarm_ack = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic set_inc(input int nh, input int nm);
      for (int i = 0; i < nh; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < nm; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic do_reset();
      expect_nx("reset24", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      expect_nx("reset12", 1'b1, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_in = 1'b0; sec_tick = 1'b0; set_mode = 1'b0; inc_hour = 1'b0; inc_min = 1'b0;
      alarm_ack = 1'b0; alarm_hour = 8'hAA; alarm_min = 8'hAA;
      @(posedge clk);
      #1;
      do_reset();
      n_tests++;
      if (h24 !== 8'h00 || m24 !== 8'h00 || s24 !== 8'h00) begin
         n_fail++;
         $display("FAIL direct_reset24: got %h:%h:%h", h24, m24, s24);
      end
      n_tests++;
      if (h12 !== 8'h12 || m12 !== 8'h00 || s12 !== 8'h00) begin
         n_fail++;
         $display("FAIL direct_reset12: got %h:%h:%h", h12, m12, s12);
      end

      // 12-hour instance: 12:59:59 -> 01:00:00, 11:59:59 -> 12:00:00
      set_inc(0, 59);
      expect_nx("h12_set", 1'b1, 8'h12, 8'h59, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_ticks(59);
      expect_nx("h12_pre", 1'b1, 8'h12, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_nx("h12_wrap", 1'b1, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      set_inc(10, 59);
      run_ticks(59);
      expect_nx("h12_11", 1'b1, 8'h11, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_nx("h12_to12", 1'b1, 8'h12, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // 60 ticks from reset: exactly one min_carry
      do_reset();
      for (int i = 1; i <= 60; i++) begin
         expect_nx("t1_tick", 1'b0, 8'h00, (i == 60) ? 8'h01 : 8'h00, bcd(i % 60),
                   (i == 60) ? 1'b1 : 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         expect_nx("t1_idle", 1'b0, 8'h00, (i == 60) ? 8'h01 : 8'h00, bcd(i % 60),
                   1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // 23:59:58 -> 23:59:59 -> 00:00:00 with both carries
      do_reset();
      set_inc(23, 59);
      expect_nx("t2_set", 1'b0, 8'h23, 8'h59, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_ticks(58);
      expect_nx("t2_58", 1'b0, 8'h23, 8'h59, 8'h58, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_nx("t2_59", 1'b0, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_nx("t2_wrap", 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (mc24 !== 1'b1 || hc24 !== 1'b1) begin
         n_fail++;
         $display("FAIL direct_t2_carries: mc=%b hc=%b", mc24, hc24);
      end
      n_tests++;
      if (h24 !== 8'h00 || m24 !== 8'h00 || s24 !== 8'h00) begin
         n_fail++;
         $display("FAIL direct_t2_wrap: got %h:%h:%h", h24, m24, s24);
      end
      expect_nx("t2_after", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Set mode: seconds forced, ticks ignored, inc wraps, combined inc
      do_reset();
      run_ticks(3);
      expect_nx("t4_run", 1'b0, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         expect_nx("t4_frozen", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      n_tests++;
      if (s24 !== 8'h00 || mc24 !== 1'b0 || hc24 !== 1'b0) begin
         n_fail++;
         $display("FAIL direct_t4_frozen: sec=%h mc=%b hc=%b", s24, mc24, hc24);
      end
      set_inc(0, 59);
      expect_nx("t4_min_wrap", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_nx("t4_min61", 1'b0, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_nx("t4_both", 1'b0, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      set_inc(22, 0);
      expect_nx("t4_hour_wrap", 1'b0, 8'h00, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_nx("t4_hour01", 1'b0, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_nx("t4_resume", 1'b0, 8'h01, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_nx("t4_inc_ignored", 1'b0, 8'h01, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

      // Reset mid-run at 05:17:33 with pulses pending
      set_inc(4, 15);
      run_ticks(33);
      expect_nx("t5_pre", 1'b0, 8'h05, 8'h17, 8'h33, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_nx("t5_reset", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if (h24 !== 8'h00 || m24 !== 8'h00 || s24 !== 8'h00 || mc24 !== 1'b0 || hc24 !== 1'b0) begin
         n_fail++;
         $display("FAIL direct_t5_reset: got %h:%h:%h mc=%b hc=%b", h24, m24, s24, mc24, hc24);
      end
      expect_nx("t5_hold", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Alarm behaviour
      do_reset();
      alarm_hour = 8'h00;
      alarm_min  = 8'h01;
`ifdef CLOCK_ALARM_EN
      run_ticks(59);
      expect_nx("a_ring", 1'b0, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_nx("a_hold", 1'b0, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_nx("a_ack", 1'b0, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      alarm_min = 8'h02;
      run_ticks(59);
      expect_nx("a_ring2", 1'b0, 8'h00, 8'h02, 8'h00, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 59; i++) begin
         expect_nx("a_ringing", 1'b0, 8'h00, 8'h02, bcd(i), 1'b0, 1'b0, 1'b1);
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      expect_nx("a_timeout", 1'b0, 8'h00, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      alarm_min = 8'h04;
      run_ticks(59);
      expect_nx("a_ack_wins", 1'b0, 8'h00, 8'h04, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      expect_nx("a_ack_after", 1'b0, 8'h00, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      alarm_min = 8'h05;
      run_ticks(59);
      expect_nx("a_ring3", 1'b0, 8'h00, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_nx("a_setclr", 1'b0, 8'h00, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`else
      run_ticks(59);
      expect_nx("noalarm", 1'b0, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_nx("noalarm_hold", 1'b0, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL %s: expectation never checked, got none, expected cycle %0d",
                  mon_e.name, mon_e.cyc);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
